// File: rtl/dcache_nway_meta.sv
// Metadata and miss control for an N-way set-associative data cache.
// Keeps valid/dirty/tag/tree-PLRU state per set, compares tags one cycle
// after a request is taken, and sequences writeback + refill on a miss.
// The data array itself lives elsewhere; this block only steers its way
// select and tells it when a refill line is on the bus.
//
// Request handshake: a request transfers on any rising edge where
// req_valid and req_ready are both high. The requester must hold req_valid,
// req_addr and req_write steady until that edge. req_ready never depends on
// req_valid, so there is no combinational loop through the requester.
module dcache_nway_meta #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3,
    parameter int NUM_WAYS = 4,
    localparam int NUM_SETS = 2 ** S_INDEX,
    localparam int S_WAY    = $clog2(NUM_WAYS),
    localparam int S_TAG    = 32 - S_OFFSET - S_INDEX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [31:0]      req_addr,
    input  logic             req_write,
    output logic             req_ready,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [S_WAY-1:0] way,
    output logic             fill_we,
    output logic             mem_read,
    output logic             mem_write,
    output logic [31:0]      mem_addr,
    input  logic             mem_resp
);

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, RESP} state_t;

    state_t             state;
    logic [S_TAG-1:0]   hold_tag;
    logic [S_INDEX-1:0] hold_idx;
    logic               hold_write;
    logic [S_WAY-1:0]   victim_q;

    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [S_TAG-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-2:0] plru_q  [NUM_SETS];

    logic             hit;
    logic [S_WAY-1:0] hit_way;
    logic             has_invalid;
    logic [S_WAY-1:0] inv_way;
    logic [S_WAY-1:0] miss_victim;
    logic             victim_dirty;
    logic             accept;

    // Heap-ordered PLRU tree: node n has children 2n+1 (lower half) and
    // 2n+2 (upper half). A 0 bit steers the victim search to the lower half.
    function automatic logic [S_WAY-1:0] plru_victim(input logic [NUM_WAYS-2:0] bits);
        int               node;
        logic [S_WAY-1:0] v;
        node = 0;
        v    = '0;
        for (int l = 0; l < S_WAY; l++) begin
            v[S_WAY-1-l] = bits[node];
            node = 2 * node + 1 + int'(bits[node]);
        end
        return v;
    endfunction

    // Point every node on the path to w away from w.
    function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] bits,
                                                       input logic [S_WAY-1:0]    w);
        int                  node;
        logic [NUM_WAYS-2:0] r;
        r    = bits;
        node = 0;
        for (int l = 0; l < S_WAY; l++) begin
            r[node] = ~w[S_WAY-1-l];
            node = 2 * node + 1 + int'(w[S_WAY-1-l]);
        end
        return r;
    endfunction

    // Tag compare of the held request against every way of its set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[hold_idx][w] && (tag_q[hold_idx][w] == hold_tag)) begin
                hit     = 1'b1;
                hit_way = S_WAY'(w);
            end
        end
    end

    // Victim choice: lowest invalid way first, otherwise the PLRU pick.
    always_comb begin
        has_invalid = 1'b0;
        inv_way     = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[hold_idx][w]) begin
                has_invalid = 1'b1;
                inv_way     = S_WAY'(w);
            end
        end
        miss_victim  = has_invalid ? inv_way : plru_victim(plru_q[hold_idx]);
        victim_dirty = valid_q[hold_idx][miss_victim] & dirty_q[hold_idx][miss_victim];
    end

    // Handshake, response and memory-port outputs decoded from the current state.
    always_comb begin
        req_ready  = (state == IDLE) || (state == RESP) || ((state == LOOKUP) && hit);
        resp_valid = ((state == LOOKUP) && hit) || (state == RESP);
        resp_hit   = (state == LOOKUP) && hit;
        mem_write  = (state == WB);
        mem_read   = (state == FILL);
        fill_we    = (state == FILL) && mem_resp;
        way        = '0;
        mem_addr   = '0;
        case (state)
            LOOKUP: way = hit ? hit_way : '0;
            WB: begin
                way      = victim_q;
                mem_addr = {tag_q[hold_idx][victim_q], hold_idx, {S_OFFSET{1'b0}}};
            end
            FILL: begin
                way      = victim_q;
                mem_addr = {hold_tag, hold_idx, {S_OFFSET{1'b0}}};
            end
            RESP: way = victim_q;
            default: ;
        endcase
    end

    assign accept = req_valid && req_ready;

    // Control FSM: request capture, miss victim latch and state sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hold_tag   <= '0;
            hold_idx   <= '0;
            hold_write <= 1'b0;
            victim_q   <= '0;
        end else begin
            if (accept) begin
                hold_tag   <= req_addr[31:32-S_TAG];
                hold_idx   <= req_addr[S_OFFSET+S_INDEX-1:S_OFFSET];
                hold_write <= req_write;
            end
            case (state)
                IDLE:   if (accept) state <= LOOKUP;
                LOOKUP: begin
                    if (hit) begin
                        state <= accept ? LOOKUP : IDLE;
                    end else begin
                        victim_q <= miss_victim;
                        state    <= victim_dirty ? WB : FILL;
                    end
                end
                WB:     if (mem_resp) state <= FILL;
                FILL:   if (mem_resp) state <= RESP;
                RESP:   state <= accept ? LOOKUP : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Valid, dirty and PLRU updates on a lookup hit or a completed refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                valid_q[i] <= '0;
                dirty_q[i] <= '0;
                plru_q[i]  <= '0;
            end
        end else if ((state == LOOKUP) && hit) begin
            plru_q[hold_idx] <= plru_touch(plru_q[hold_idx], hit_way);
            if (hold_write) dirty_q[hold_idx][hit_way] <= 1'b1;
        end else if ((state == FILL) && mem_resp) begin
            valid_q[hold_idx][victim_q] <= 1'b1;
            dirty_q[hold_idx][victim_q] <= hold_write;
            plru_q[hold_idx]            <= plru_touch(plru_q[hold_idx], victim_q);
        end
    end

    // Tag storage; contents are only meaningful where the valid bit is set.
    always_ff @(posedge clk) begin
        if ((state == FILL) && mem_resp) tag_q[hold_idx][victim_q] <= hold_tag;
    end

endmodule

// File: tb/tb_dcache_nway_meta.sv
// Directed bench for dcache_nway_meta: a table of single requests with
// hand-computed hit/way/writeback/refill results, plus short sequences for
// back-to-back hits, reset during refill and stray mem_resp pulses.
module tb_dcache_nway_meta;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_write;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_hit;
    logic [1:0]  way;
    logic        fill_we;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic        mem_resp;

    int n_vec = 0;
    int n_err = 0;

    dcache_nway_meta dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_hit(resp_hit),
        .way(way), .fill_we(fill_we), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_resp(mem_resp)
    );

    // clock
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_before;
        logic [31:0] addr;
        logic        wr;
        logic        exp_hit;
        logic [1:0]  exp_way;
        logic        exp_wb;
        logic [31:0] exp_wb_addr;
        logic [31:0] exp_fill_addr;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0; mem_resp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One request; services WB/FILL with a fixed 3-cycle memory latency.
    task automatic do_req(input logic [31:0] a, input logic w,
                          output logic hit, output logic [1:0] rway,
                          output logic wb, output logic [31:0] wba,
                          output logic [31:0] fa, output logic [1:0] fway,
                          output int lat);
        int cyc, wait_c, fill_cyc;
        logic done, held_vld;
        logic [31:0] held_addr;
        hit = 0; rway = 0; wb = 0; wba = 0; fa = 0; fway = 0; lat = -1;
        fill_cyc = -10; held_addr = 0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_write = w;
        cyc = 0;
        while (!req_ready && cyc < 20) begin @(negedge clk); cyc++; end
        @(negedge clk);
        req_valid = 1'b0; req_addr = 0; req_write = 0;
        cyc = 0; done = 0; wait_c = 0; held_vld = 0;
        while (!done && cyc < 200) begin
            mem_resp = 1'b0;
            #1;
            if (mem_read && mem_write) chk("mem_rd_wr_both", 1, 0);
            if (mem_read || mem_write) begin
                if (!held_vld) begin held_addr = mem_addr; held_vld = 1; end
                else chk("mem_addr_stable", mem_addr, held_addr);
                if (mem_write) begin wb = 1; wba = mem_addr; end
                if (mem_read) fa = mem_addr;
                wait_c++;
                if (wait_c == 3) begin
                    mem_resp = 1'b1;
                    #1;
                    if (mem_read) begin
                        chk("fill_we_on_resp", fill_we, 1);
                        fway = way;
                        fill_cyc = cyc;
                    end else begin
                        chk("fill_we_in_wb", fill_we, 0);
                    end
                    wait_c = 0; held_vld = 0;
                end
            end
            if (resp_valid) begin
                hit = resp_hit; rway = way; lat = cyc; done = 1;
                if (!resp_hit) chk("miss_resp_latency", cyc, fill_cyc + 1);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) chk("req_timeout", 0, 1);
    endtask

    initial begin
        logic hit, wb;
        logic [1:0] rway, fway;
        logic [31:0] wba, fa;
        int lat;

        // set 0 fills, PLRU victim, dirty writeback, second set
        vecs[0]  = '{1'b1, 32'h1000, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0,    32'h1000};
        vecs[1]  = '{1'b0, 32'h1004, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0,    32'h0};
        vecs[2]  = '{1'b0, 32'h2000, 1'b0, 1'b0, 2'd1, 1'b0, 32'h0,    32'h2000};
        vecs[3]  = '{1'b0, 32'h3000, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0,    32'h3000};
        vecs[4]  = '{1'b0, 32'h4000, 1'b0, 1'b0, 2'd3, 1'b0, 32'h0,    32'h4000};
        vecs[5]  = '{1'b0, 32'h5000, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0,    32'h5000};
        vecs[6]  = '{1'b1, 32'h1000, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,    32'h1000};
        vecs[7]  = '{1'b0, 32'h2000, 1'b0, 1'b0, 2'd1, 1'b0, 32'h0,    32'h2000};
        vecs[8]  = '{1'b0, 32'h3000, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0,    32'h3000};
        vecs[9]  = '{1'b0, 32'h4000, 1'b0, 1'b0, 2'd3, 1'b0, 32'h0,    32'h4000};
        vecs[10] = '{1'b0, 32'h5000, 1'b0, 1'b0, 2'd0, 1'b1, 32'h1000, 32'h5000};
        vecs[11] = '{1'b0, 32'h5008, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0,    32'h0};
        vecs[12] = '{1'b0, 32'h2010, 1'b1, 1'b1, 2'd1, 1'b0, 32'h0,    32'h0};
        vecs[13] = '{1'b0, 32'h6000, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0,    32'h6000};
        vecs[14] = '{1'b0, 32'h7000, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0,    32'h7000};
        vecs[15] = '{1'b0, 32'h8000, 1'b0, 1'b0, 2'd3, 1'b0, 32'h0,    32'h8000};
        vecs[16] = '{1'b0, 32'h9000, 1'b0, 1'b0, 2'd1, 1'b1, 32'h2000, 32'h9000};
        vecs[17] = '{1'b0, 32'h1020, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0,    32'h1020};
        vecs[18] = '{1'b0, 32'h6004, 1'b0, 1'b1, 2'd2, 1'b0, 32'h0,    32'h0};

        rst = 1'b1; req_valid = 1'b0; req_addr = 0; req_write = 0; mem_resp = 1'b0;

        // reset values while rst is held
        #3;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_hit", resp_hit, 0);
        chk("rst_fill_we", fill_we, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_way", way, 0);
        chk("rst_mem_addr", mem_addr, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // table of single requests
        for (int i = 0; i < 19; i++) begin
            if (vecs[i].rst_before) do_reset();
            do_req(vecs[i].addr, vecs[i].wr, hit, rway, wb, wba, fa, fway, lat);
            chk($sformatf("v%0d_hit", i), hit, vecs[i].exp_hit);
            chk($sformatf("v%0d_way", i), rway, vecs[i].exp_way);
            if (vecs[i].exp_hit) begin
                chk($sformatf("v%0d_hit_latency", i), lat, 0);
            end else begin
                chk($sformatf("v%0d_wb", i), wb, vecs[i].exp_wb);
                if (vecs[i].exp_wb) chk($sformatf("v%0d_wb_addr", i), wba, vecs[i].exp_wb_addr);
                chk($sformatf("v%0d_fill_addr", i), fa, vecs[i].exp_fill_addr);
                chk($sformatf("v%0d_fill_way", i), fway, vecs[i].exp_way);
            end
        end

        // back-to-back hits with req_valid held
        do_reset();
        do_req(32'h1000, 1'b0, hit, rway, wb, wba, fa, fway, lat);
        chk("b2b_setup_way", rway, 0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1000;
        #1 chk("b2b_ready0", req_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_addr = (i < 3) ? 32'h1000 + 32'((i + 1) * 4) : 32'h0;
            if (i == 3) req_valid = 1'b0;
            #1;
            chk($sformatf("b2b_resp_valid%0d", i), resp_valid, 1);
            chk($sformatf("b2b_resp_hit%0d", i), resp_hit, 1);
            chk($sformatf("b2b_way%0d", i), way, 0);
            chk($sformatf("b2b_ready%0d", i + 1), req_ready, 1);
        end
        @(negedge clk);
        #1 chk("b2b_after_resp_valid", resp_valid, 0);

        // reset during refill of 0x6000
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h6000; req_write = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        begin
            int c;
            c = 0;
            #1;
            while (!mem_read && c < 10) begin @(negedge clk); #1; c++; end
            chk("rstfill_in_fill", mem_read, 1);
            chk("rstfill_addr", mem_addr, 32'h6000);
        end
        rst = 1'b1;
        #1;
        chk("rstfill_mem_read_drop", mem_read, 0);
        chk("rstfill_mem_write", mem_write, 0);
        @(negedge clk);
        rst = 1'b0;
        do_req(32'h6000, 1'b0, hit, rway, wb, wba, fa, fway, lat);
        chk("rstfill_6000_miss", hit, 0);
        chk("rstfill_6000_way", rway, 0);
        do_req(32'h1000, 1'b0, hit, rway, wb, wba, fa, fway, lat);
        chk("rstfill_1000_miss", hit, 0);
        chk("rstfill_1000_way", rway, 1);
        chk("rstfill_1000_wb", wb, 0);

        // stray mem_resp in IDLE and on a LOOKUP hit
        @(negedge clk);
        mem_resp = 1'b1;
        #1;
        chk("stray_idle_fill_we", fill_we, 0);
        chk("stray_idle_mem_read", mem_read, 0);
        @(negedge clk);
        mem_resp = 1'b0;
        req_valid = 1'b1; req_addr = 32'h1000; req_write = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        mem_resp = 1'b1;
        #1;
        chk("stray_lookup_hit", resp_hit, 1);
        chk("stray_lookup_way", way, 1);
        chk("stray_lookup_fill_we", fill_we, 0);
        @(negedge clk);
        mem_resp = 1'b0;
        #1;
        chk("stray_after_resp_valid", resp_valid, 0);
        chk("stray_after_mem_read", mem_read, 0);
        chk("stray_after_mem_write", mem_write, 0);
        do_req(32'h1000, 1'b0, hit, rway, wb, wba, fa, fway, lat);
        chk("stray_meta_1000_hit", hit, 1);
        chk("stray_meta_1000_way", rway, 1);
        do_req(32'h6000, 1'b0, hit, rway, wb, wba, fa, fway, lat);
        chk("stray_meta_6000_hit", hit, 1);
        chk("stray_meta_6000_way", rway, 0);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // hard time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

endmodule
